// File: rtl/ec_lab_pkg.sv
// Shared types and helpers for the serial lab link (receiver now, transmitter later).
package ec_lab_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        RESYNC
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Zero padding up to 16 bits leaves the XOR reduction unchanged.
    function automatic logic parity_exp(input logic [15:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/serial_parity_rx_if.sv
// Serial-in / frame-out bundle of the parity receiver; master drives the line, slave is the receiver.
interface serial_parity_rx_if #(
    parameter int DATA_W = 8
);

    logic              sdata_in;
    logic              svalid_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output sdata_in, svalid_in,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  sdata_in, svalid_in,
        output data_out, data_valid, parity_err, frame_err, busy
    );

endinterface

// File: rtl/parity_calc.sv
// Expected parity of a data word (XNOR-reduce when PARITY_ODD, else XOR-reduce).
// Purely combinational, no handshake; shared by receiver and transmitter.
module parity_calc
    import ec_lab_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 1
) (
    input  logic [DATA_W-1:0] data,
    output logic              p_exp
);

    assign p_exp = parity_exp(16'(data), PARITY_ODD != 0);

endmodule

// File: rtl/serial_parity_rx.sv
// Bit-serial start/data/parity/stop receiver with parity and stop-bit checking.
// Result registered 1 clk after the stop bit; svalid_in=0 cycles freeze the receiver (no backpressure).
module serial_parity_rx
    import ec_lab_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic              clk,
    input  logic              rst,
    serial_parity_rx_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    rx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic              p_exp;

    parity_calc #(
        .DATA_W     (DATA_W),
        .PARITY_ODD (PARITY_ODD)
    ) u_parity_calc (
        .data  (shreg_q),
        .p_exp (p_exp)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        par_d        = par_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if (bus.svalid_in) begin
            case (state_q)
                IDLE: begin
                    if (bus.sdata_in != LINE_IDLE) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    if (MSB_FIRST != 0)
                        shreg_d = (shreg_q << 1) | DATA_W'(bus.sdata_in);
                    else
                        shreg_d = (shreg_q >> 1) | (DATA_W'(bus.sdata_in) << (DATA_W - 1));
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1))
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = bus.sdata_in;
                    state_d = STOP;
                end
                STOP: begin
                    // The frame is reported even when the stop bit is bad.
                    data_valid_d = 1'b1;
                    data_out_d   = shreg_q;
                    parity_err_d = (par_q != p_exp);
                    frame_err_d  = (bus.sdata_in != LINE_IDLE);
                    state_d      = (bus.sdata_in == LINE_IDLE) ? IDLE : RESYNC;
                end
                RESYNC: begin
                    if (bus.sdata_in == LINE_IDLE)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            par_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            par_q        <= par_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: default config plus even-parity and LSB-first instances.
module tb_serial_parity_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] sd;
    logic [2:0] sv;

    // Per instance: 0 = odd/MSB-first, 1 = even/MSB-first, 2 = odd/LSB-first.
    localparam logic [2:0] P_ODD = 3'b101;
    localparam logic [2:0] P_MSB = 3'b011;

    serial_parity_rx_if #(.DATA_W(8)) bus0 ();
    serial_parity_rx_if #(.DATA_W(8)) bus1 ();
    serial_parity_rx_if #(.DATA_W(8)) bus2 ();

    assign bus0.sdata_in  = sd[0];
    assign bus0.svalid_in = sv[0];
    assign bus1.sdata_in  = sd[1];
    assign bus1.svalid_in = sv[1];
    assign bus2.sdata_in  = sd[2];
    assign bus2.svalid_in = sv[2];

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1), .MSB_FIRST(1)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave));
    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(0), .MSB_FIRST(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave));
    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1), .MSB_FIRST(0)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave));

    int total = 0;
    int bad   = 0;
    int pulses [3];
    int flag_viol = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {busy, data_valid, parity_err, frame_err, data_out}
    function automatic logic [11:0] outs(input int i);
        case (i)
            0:       return {bus0.busy, bus0.data_valid, bus0.parity_err, bus0.frame_err, bus0.data_out};
            1:       return {bus1.busy, bus1.data_valid, bus1.parity_err, bus1.frame_err, bus1.data_out};
            default: return {bus2.busy, bus2.data_valid, bus2.parity_err, bus2.frame_err, bus2.data_out};
        endcase
    endfunction

    // Sampled 1 time unit after each rising edge, clear of the DUT update.
    always @(posedge clk) begin
        #1;
        if (bus0.data_valid) pulses[0]++;
        if (bus1.data_valid) pulses[1]++;
        if (bus2.data_valid) pulses[2]++;
        if (!bus0.data_valid && (bus0.parity_err || bus0.frame_err)) flag_viol++;
        if (!bus1.data_valid && (bus1.parity_err || bus1.frame_err)) flag_viol++;
        if (!bus2.data_valid && (bus2.parity_err || bus2.frame_err)) flag_viol++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input int i, input logic b);
        sd[i] = b;
        sv[i] = 1'b1;
        @(negedge clk);
        sv[i] = 1'b0;
        sd[i] = 1'b1;
    endtask

    task automatic gap(input int maxgap);
        if (maxgap > 0)
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
    endtask

    task automatic send_body(input int i, input logic [7:0] d, input logic pflip, input int maxgap);
        logic p;
        p = (P_ODD[i] ? ~^d : ^d) ^ pflip;
        gap(maxgap);
        send_bit(i, 1'b0);
        for (int k = 0; k < 8; k++) begin
            gap(maxgap);
            send_bit(i, P_MSB[i] ? d[7-k] : d[k]);
        end
        gap(maxgap);
        send_bit(i, p);
    endtask

    task automatic send_frame(input int i, input logic [7:0] d, input logic pflip, input logic stop);
        send_body(i, d, pflip, 0);
        send_bit(i, stop);
    endtask

    task automatic chk_frame(input string tag, input int i, input logic [7:0] d,
                             input logic pe, input logic fe);
        logic [11:0] o;
        o = outs(i);
        chk({tag, "_vld"}, 32'(o[10]), 32'd1);
        chk({tag, "_data"}, 32'(o[7:0]), 32'(d));
        chk({tag, "_perr"}, 32'(o[9]), 32'(pe));
        chk({tag, "_ferr"}, 32'(o[8]), 32'(fe));
    endtask

    initial begin
        int pc;
        logic [11:0] o;

        rst = 1'b1;
        sd  = 3'b111;
        sv  = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        o = outs(0);
        chk("rst_data", 32'(o[7:0]), 32'h0);
        chk("rst_vld", 32'(o[10]), 32'd0);
        chk("rst_perr", 32'(o[9]), 32'd0);
        chk("rst_ferr", 32'(o[8]), 32'd0);
        chk("rst_busy", 32'(o[11]), 32'd0);
        @(negedge clk);

        // 1: clean A5 frame, one-cycle pulse, data holds afterwards
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        chk_frame("t1", 0, 8'hA5, 1'b0, 1'b0);
        chk("t1_busy", 32'(outs(0) >> 11), 32'd0);
        @(negedge clk);
        o = outs(0);
        chk("t1_width", 32'(o[10]), 32'd0);
        chk("t1_hold", 32'(o[7:0]), 32'hA5);
        chk("t1_pulses", 32'(pulses[0]), 32'd1);

        // 2: parity bit flipped
        send_frame(0, 8'hA5, 1'b1, 1'b1);
        chk_frame("t2", 0, 8'hA5, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // 3: bad stop, zeros swallowed in RESYNC, then a clean frame
        send_frame(0, 8'h0F, 1'b0, 1'b0);
        chk_frame("t3a", 0, 8'h0F, 1'b0, 1'b1);
        chk("t3_resync_busy", 32'(outs(0) >> 11), 32'd1);
        repeat (3) send_bit(0, 1'b0);
        o = outs(0);
        chk("t3_zeros_busy", 32'(o[11]), 32'd1);
        chk("t3_zeros_vld", 32'(o[10]), 32'd0);
        send_bit(0, 1'b1);
        chk("t3_idle", 32'(outs(0) >> 11), 32'd0);
        pc = pulses[0];
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        chk_frame("t3b", 0, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_pulses", 32'(pulses[0] - pc), 32'd1);

        // 4: random gaps between bits
        pc = pulses[0];
        send_body(0, 8'h81, 1'b0, 5);
        gap(5);
        chk("t4_no_early", 32'(pulses[0] - pc), 32'd0);
        send_bit(0, 1'b1);
        chk_frame("t4", 0, 8'h81, 1'b0, 1'b0);
        @(negedge clk);

        // 5: reset after four data bits of FF
        pc = pulses[0];
        send_bit(0, 1'b0);
        repeat (4) send_bit(0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        o = outs(0);
        chk("t5_rst_outs", 32'(o), 32'h0);
        repeat (3) @(negedge clk);
        chk("t5_no_pulse", 32'(pulses[0] - pc), 32'd0);
        send_frame(0, 8'h55, 1'b0, 1'b1);
        chk_frame("t5", 0, 8'h55, 1'b0, 1'b0);
        @(negedge clk);

        // 6: back-to-back 00/FF on every configuration, plus order/parity discriminators
        for (int i = 0; i < 3; i++) begin
            send_frame(i, 8'h00, 1'b0, 1'b1);
            chk_frame($sformatf("t6_%0d_00", i), i, 8'h00, 1'b0, 1'b0);
            send_frame(i, 8'hFF, 1'b0, 1'b1);
            chk_frame($sformatf("t6_%0d_ff", i), i, 8'hFF, 1'b0, 1'b0);
            @(negedge clk);
        end
        send_frame(1, 8'h07, 1'b0, 1'b1);
        chk_frame("t6_even_07", 1, 8'h07, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        chk_frame("t6_even_07_bad", 1, 8'h07, 1'b1, 1'b0);
        send_frame(2, 8'h07, 1'b0, 1'b1);
        chk_frame("t6_lsb_07", 2, 8'h07, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_pulses1", 32'(pulses[1]), 32'd4);
        chk("t6_pulses2", 32'(pulses[2]), 32'd3);

        chk("flag_quiet", 32'(flag_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
